// File: rtl/regfile_hazard.sv
// Register file with a per-register pending (scoreboard) bit, optional
// write-to-read forwarding, flush of outstanding producers and a popcount of pending registers.
module regfile_hazard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int BYPASS        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0]    rd1,
  output logic [DATA_WIDTH-1:0]    rd2,
  output logic                     rd1_busy,
  output logic                     rd2_busy,
  input  logic                     issue_en,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic                     wb_en,
  input  logic [ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic [ADDRESS_WIDTH:0]   busy_count
);

  localparam int  NREGS     = 2 ** ADDRESS_WIDTH;
  localparam bit  BYPASS_EN = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0]      pending_q;
  logic [NREGS-1:0]      pending_d;
  logic                  bypass1;
  logic                  bypass2;

  // NOTE: the register array sits inside the async reset because the whole
  // architectural state must read zero the instant rst_n falls; no RAM macro here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Later statements override earlier ones: issue beats write-back (the newer
  // producer is still outstanding) and flush beats both.
  always_comb begin
    // NOTE: start from the held value so every path assigns pending_d (no latch).
    pending_d = pending_q;
    if (wb_en)    pending_d[wb_addr]  = 1'b0;
    if (issue_en) pending_d[issue_rd] = 1'b1;
    if (flush)    pending_d           = '0;
    pending_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Forwarding is suppressed while reset is asserted so all read data is zero.
  assign bypass1 = BYPASS_EN && rst_n && wb_en && (wb_addr == rs1) && (rs1 != '0);
  assign bypass2 = BYPASS_EN && rst_n && wb_en && (wb_addr == rs2) && (rs2 != '0);

  assign rd1      = bypass1 ? wb_data : regs_q[rs1];
  assign rd2      = bypass2 ? wb_data : regs_q[rs2];
  assign rd1_busy = pending_q[rs1] & ~bypass1;
  assign rd2_busy = pending_q[rs2] & ~bypass2;

  generate
    if (NREGS > 10) begin : g_a0
      assign a0 = regs_q[10];
    end else begin : g_no_a0
      assign a0 = '0;
    end
  endgenerate

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_count = busy_count + (ADDRESS_WIDTH + 1)'(pending_q[i]);
    end
  end

endmodule

// File: tb/tb_regfile_hazard.sv
// Randomized and directed bench for regfile_hazard: one instance with forwarding,
// one without, both compared against an array-based reference model.
module tb_regfile_hazard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rs1, rs2, issue_rd, wb_addr;
  logic          issue_en, wb_en, flush;
  logic [DW-1:0] wb_data;

  logic [DW-1:0] rd1_on, rd2_on, a0_on, rd1_off, rd2_off, a0_off;
  logic          rd1_busy_on, rd2_busy_on, rd1_busy_off, rd2_busy_off;
  logic [AW:0]   busy_count_on, busy_count_off;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] mregs [N];
  bit            mpend [N];

  always #5 clk = ~clk;

  regfile_hazard #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1)) dut_on (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd1(rd1_on), .rd2(rd2_on),
    .rd1_busy(rd1_busy_on), .rd2_busy(rd2_busy_on), .issue_en(issue_en),
    .issue_rd(issue_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .a0(a0_on), .busy_count(busy_count_on)
  );

  regfile_hazard #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(0)) dut_off (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd1(rd1_off), .rd2(rd2_off),
    .rd1_busy(rd1_busy_off), .rd2_busy(rd2_busy_off), .issue_en(issue_en),
    .issue_rd(issue_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .a0(a0_off), .busy_count(busy_count_off)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] exp_rd(input bit byp, input logic [AW-1:0] rs);
    if (rs == 0) return '0;
    if (byp && wb_en && wb_addr == rs) return wb_data;
    return mregs[rs];
  endfunction

  function automatic bit exp_busy(input bit byp, input logic [AW-1:0] rs);
    if (byp && wb_en && wb_addr == rs) return 1'b0;
    return mpend[rs];
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mpend[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mregs[i] = '0;
      mpend[i] = 1'b0;
    end
  endtask

  // Applies the edge rules to the model using the inputs present at the edge.
  task automatic model_edge();
    if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
    if (flush) begin
      for (int i = 0; i < N; i++) mpend[i] = 1'b0;
    end else begin
      if (wb_en) mpend[wb_addr] = 1'b0;
      if (issue_en && issue_rd != 0) mpend[issue_rd] = 1'b1;
    end
  endtask

  task automatic drive(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic ie, input logic [AW-1:0] ird,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic fl);
    rs1 = r1; rs2 = r2; issue_en = ie; issue_rd = ird;
    wb_en = we; wb_addr = wa; wb_data = wd; flush = fl;
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    drive(r1, r2, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Settle the combinational outputs, then compare both instances with the model.
  task automatic eval();
    #1;
    check("rd1_byp",   rd1_on,       exp_rd(1'b1, rs1));
    check("rd2_byp",   rd2_on,       exp_rd(1'b1, rs2));
    check("busy1_byp", 32'(rd1_busy_on), 32'(exp_busy(1'b1, rs1)));
    check("busy2_byp", 32'(rd2_busy_on), 32'(exp_busy(1'b1, rs2)));
    check("a0_byp",    a0_on,        mregs[10]);
    check("cnt_byp",   32'(busy_count_on), 32'(model_count()));
    check("rd1_nob",   rd1_off,      exp_rd(1'b0, rs1));
    check("rd2_nob",   rd2_off,      exp_rd(1'b0, rs2));
    check("busy1_nob", 32'(rd1_busy_off), 32'(exp_busy(1'b0, rs1)));
    check("busy2_nob", 32'(rd2_busy_off), 32'(exp_busy(1'b0, rs2)));
    check("a0_nob",    a0_off,       mregs[10]);
    check("cnt_nob",   32'(busy_count_off), 32'(model_count()));
  endtask

  task automatic commit();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_reset_zero();
    check("rst_rd1",   rd1_on, '0);
    check("rst_rd2",   rd2_on, '0);
    check("rst_a0",    a0_on, '0);
    check("rst_busy1", 32'(rd1_busy_on), 0);
    check("rst_busy2", 32'(rd2_busy_on), 0);
    check("rst_cnt",   32'(busy_count_on), 0);
    check("rst_rd1_nob", rd1_off, '0);
    check("rst_a0_nob",  a0_off, '0);
    check("rst_cnt_nob", 32'(busy_count_off), 0);
  endtask

  // Pulses reset between edges with a bypass-capable write on the bus.
  task automatic reset_pulse();
    drive(5'd10, 5'd6, 1'b1, 5'd6, 1'b1, 5'd10, 32'hFFFF_0000, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_reset_zero();
    model_clear();
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 11));
    return AW'($urandom_range(0, N - 1));
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    idle(5'd0, 5'd0);
    #3 check_reset_zero();
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read; x0 ignores writes.
    drive(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    eval(); commit();
    drive(5'd5, 5'd0, 1'b0, '0, 1'b1, 5'd0, 32'h0000_1234, 1'b0);
    eval();
    check("x5_read", rd1_on, 32'hDEAD_BEEF);
    commit();
    idle(5'd5, 5'd0);
    eval();
    check("x0_zero", rd2_on, '0);
    check("x0_cnt", 32'(busy_count_on), 0);
    commit();

    // Forwarding on vs. off.
    drive(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd7, 32'h1111_1111, 1'b0);
    eval(); commit();
    drive(5'd7, 5'd0, 1'b0, '0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0);
    eval();
    check("byp_rd1", rd1_on, 32'hA5A5_A5A5);
    check("byp_busy", 32'(rd1_busy_on), 0);
    check("nobyp_rd1", rd1_off, 32'h1111_1111);
    commit();

    // Scoreboard set and clear.
    drive(5'd0, 5'd0, 1'b1, 5'd3, 1'b0, '0, '0, 1'b0);
    eval(); commit();
    idle(5'd3, 5'd0);
    eval();
    check("x3_busy", 32'(rd1_busy_on), 1);
    check("x3_cnt", 32'(busy_count_on), 1);
    commit();
    drive(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd3, 32'h0000_0033, 1'b0);
    eval(); commit();
    idle(5'd3, 5'd0);
    eval();
    check("x3_free", 32'(rd1_busy_on), 0);
    check("x3_cnt0", 32'(busy_count_on), 0);
    commit();

    // Same-edge issue and write-back: set wins, data still lands.
    drive(5'd0, 5'd0, 1'b1, 5'd4, 1'b0, '0, '0, 1'b0);
    eval(); commit();
    drive(5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 5'd4, 32'h0000_CAFE, 1'b0);
    eval(); commit();
    idle(5'd4, 5'd0);
    eval();
    check("x4_busy", 32'(rd1_busy_on), 1);
    check("x4_data", rd1_on, 32'h0000_CAFE);
    commit();

    // Flush overrides a same-cycle issue.
    drive(5'd0, 5'd0, 1'b1, 5'd8, 1'b0, '0, '0, 1'b0);
    eval(); commit();
    drive(5'd0, 5'd0, 1'b1, 5'd9, 1'b0, '0, '0, 1'b0);
    eval(); commit();
    drive(5'd8, 5'd9, 1'b1, 5'd10, 1'b0, '0, '0, 1'b1);
    eval();
    check("pre_flush_cnt", 32'(busy_count_on), 3);
    commit();
    idle(5'd10, 5'd8);
    eval();
    check("flush_cnt", 32'(busy_count_on), 0);
    commit();

    // Reset mid-operation.
    drive(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd10, 32'h0000_0055, 1'b0);
    eval(); commit();
    drive(5'd0, 5'd0, 1'b1, 5'd6, 1'b0, '0, '0, 1'b0);
    eval(); commit();
    idle(5'd6, 5'd10);
    eval();
    check("pre_rst_a0", a0_on, 32'h0000_0055);
    check("pre_rst_cnt", 32'(busy_count_on), 1);
    reset_pulse();
    drive(5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd10, 32'h0000_0077, 1'b0);
    eval(); commit();
    idle(5'd10, 5'd6);
    eval();
    check("post_rst_a0", a0_on, 32'h0000_0077);
    commit();

    // Randomized traffic, with occasional flushes and reset pulses.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) reset_pulse();
      drive(pick_addr(), pick_addr(),
            1'($urandom_range(0, 1)), pick_addr(),
            1'($urandom_range(0, 2) != 0), pick_addr(), DW'($urandom()),
            1'($urandom_range(0, 15) == 0));
      eval();
      commit();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_hazard.md
REGFILE_HAZARD -- requirements
Module: regfile_hazard

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, register index width; the block SHALL hold 2**ADDRESS_WIDTH registers.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 Parameter BYPASS, default 1; 1 SHALL enable write-to-read forwarding, 0 SHALL disable it.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rs1, rs2  input  ADDRESS_WIDTH  read port addresses.
REQ-007 rd1, rd2  output  DATA_WIDTH  read port data.
REQ-008 rd1_busy, rd2_busy  output  1  addressed register has an outstanding producer.
REQ-009 issue_en  input  1  an instruction writing issue_rd is issued this cycle.
REQ-010 issue_rd  input  ADDRESS_WIDTH  destination of the issued instruction.
REQ-011 wb_en  input  1  write-back valid.
REQ-012 wb_addr  input  ADDRESS_WIDTH  write-back destination.
REQ-013 wb_data  input  DATA_WIDTH  write-back data.
REQ-014 flush  input  1  discard all outstanding producers.
REQ-015 a0  output  DATA_WIDTH  stored contents of register 10, no forwarding.
REQ-016 busy_count  output  ADDRESS_WIDTH+1  number of registers currently pending.

Function
REQ-017 Register 0 SHALL read as zero, SHALL ignore writes, and SHALL never become pending.
REQ-018 On posedge with wb_en=1 and wb_addr!=0, register[wb_addr] SHALL take wb_data.
REQ-019 Reads SHALL be combinational: rdN = register[rsN], zero-latency.
REQ-020 With BYPASS=1, wb_en=1, wb_addr==rsN and rsN!=0: rdN SHALL equal wb_data in the same cycle.
REQ-021 The block SHALL keep one pending bit per register.
REQ-022 issue_en=1 with issue_rd!=0 SHALL set pending[issue_rd] at the next edge.
REQ-023 wb_en=1 SHALL clear pending[wb_addr] at the next edge.
REQ-024 Same-edge issue_en and wb_en to the same address: set SHALL win, because the newer producer is outstanding.
REQ-025 flush=1 SHALL clear every pending bit at the next edge and SHALL override a same-cycle issue; a same-cycle write-back data write SHALL still occur.
REQ-026 rdN_busy SHALL equal pending[rsN], except it SHALL be 0 when BYPASS=1, wb_en=1 and wb_addr==rsN in the same cycle.
REQ-027 Issue to an already-pending register (WAW) SHALL be legal; the bit SHALL stay set until a later write-back.
REQ-028 busy_count SHALL equal the population count of the pending bits, range 0..2**ADDRESS_WIDTH-1.
REQ-029 a0 SHALL reflect register[10] as stored after the last edge; it SHALL NOT be bypassed.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, clear all registers and all pending bits.
REQ-031 During reset, rd1, rd2 and a0 SHALL read 0, rd1_busy and rd2_busy SHALL be 0, and busy_count SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard outstanding writes and issues; the first edge after rst_n rises SHALL behave as a normal cycle.

Verification
REQ-033 Write and read: wb x5=0xDEADBEEF, next cycle rs1=5 -> rd1=0xDEADBEEF; write x0=0x1234 -> rs2=0 gives rd2=0, busy_count 0.
REQ-034 Bypass: same cycle wb x7=0xA5A5A5A5 and rs1=7 -> rd1=0xA5A5A5A5, rd1_busy=0; with BYPASS=0 -> rd1=old x7 value.
REQ-035 Scoreboard: issue x3, next cycle rs1=3 -> rd1_busy=1, busy_count=1; wb x3 -> following cycle rd1_busy=0, busy_count=0.
REQ-036 Simultaneous events: x4 pending, issue x4 and wb x4 same edge -> x4 still pending and holds new data; issue x8,x9 then flush with issue x10 -> busy_count=0.
REQ-037 Reset mid-operation: x10=0x55 and x6 pending, pulse rst_n low between edges -> a0=0 and busy_count=0 immediately; wb x10=0x77 after release -> a0=0x77.
